// File: rtl/i281_wb_pkg.sv
// Shared definitions for the i281 register-file writeback path.
// A writeback entry is stored as the concatenation {sel, data}, sel in the upper bits.
package i281_wb_pkg;

  localparam int WB_DATA_W   = 8;
  localparam int WB_SEL_W    = 2;
  localparam int WB_DEPTH    = 4;
  localparam int WB_NUM_REGS = 1 << WB_SEL_W;

  typedef enum logic [WB_SEL_W-1:0] {
    REG_A = 2'd0,
    REG_B = 2'd1,
    REG_C = 2'd2,
    REG_D = 2'd3
  } reg_sel_e;

  typedef struct packed {
    logic [WB_SEL_W-1:0]  sel;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic wb_entry_t make_entry(input logic [WB_SEL_W-1:0] sel,
                                           input logic [WB_DATA_W-1:0] data);
    wb_entry_t e;
    e.sel  = sel;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO holding pending register writebacks.
// Push is ignored when full and pop is ignored when empty; full/empty come from the registered count.
// Optional macro WB_BYPASS_EN exposes the storage and read pointer for the bypass search.
module wb_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
`ifdef WB_BYPASS_EN
  ,
  output logic [DEPTH*WIDTH-1:0] slots,
  output logic [PTR_W-1:0]       rd_ptr_out
`endif
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

`ifdef WB_BYPASS_EN
  for (genvar i = 0; i < DEPTH; i++) begin : g_slots
    assign slots[i*WIDTH +: WIDTH] = mem[i];
  end
  assign rd_ptr_out = rd_ptr;
`endif

  // Storage array; contents need no reset because count gates every use.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback producer for the i281 4x8 register file.
// Arbitrates ALU and LOAD requests (load wins) into an in-order queue, retires one write per
// cycle through a registered write stage, and keeps per-register pending counters for RAW stalls.
// Optional macro WB_BYPASS_EN adds two combinational bypass query ports.
module reg_writeback_queue
  import i281_wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int SEL_W  = WB_SEL_W,
  parameter int DEPTH  = WB_DEPTH,
  localparam int NUM_REGS = 1 << SEL_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_wb_valid,
  input  logic [SEL_W-1:0]    alu_wb_select,
  input  logic [DATA_W-1:0]   alu_wb_data,
  output logic                alu_wb_ready,
  input  logic                load_wb_valid,
  input  logic [SEL_W-1:0]    load_wb_select,
  input  logic [DATA_W-1:0]   load_wb_data,
  output logic                load_wb_ready,
  input  logic                drain_stall,
  output logic                write_enable,
  output logic [SEL_W-1:0]    write_select,
  output logic [DATA_W-1:0]   reg_input,
  output logic [NUM_REGS-1:0] pending,
  output logic                empty
`ifdef WB_BYPASS_EN
  ,
  input  logic [SEL_W-1:0]    query_select0,
  input  logic [SEL_W-1:0]    query_select1,
  output logic                bypass_hit0,
  output logic                bypass_hit1,
  output logic [DATA_W-1:0]   bypass_data0,
  output logic [DATA_W-1:0]   bypass_data1
`endif
);

  localparam int ENTRY_W = SEL_W + DATA_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int SB_W    = $clog2(DEPTH + 2);

  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [SB_W-1:0]    sb_count [NUM_REGS];
  logic [NUM_REGS-1:0] sb_inc;
  logic [NUM_REGS-1:0] sb_dec;

  // Readiness depends only on the registered occupancy, so a full queue never
  // accepts in the same cycle it pops.
  assign load_wb_ready = ~fifo_full;
  assign alu_wb_ready  = ~fifo_full & ~load_wb_valid;
  assign push          = (load_wb_valid | alu_wb_valid) & ~fifo_full;
  assign push_entry    = load_wb_valid ? {load_wb_select, load_wb_data}
                                       : {alu_wb_select, alu_wb_data};
  assign pop           = ~fifo_empty & ~drain_stall;
  assign empty         = (fifo_count == '0) & ~write_enable;

`ifdef WB_BYPASS_EN
  localparam int PTR_W = $clog2(DEPTH);
  logic [DEPTH*ENTRY_W-1:0] fifo_slots;
  logic [PTR_W-1:0]         fifo_rd_ptr;
`endif

  wb_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head_data  (head_entry),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
`ifdef WB_BYPASS_EN
    ,
    .slots      (fifo_slots),
    .rd_ptr_out (fifo_rd_ptr)
`endif
  );

  // Write stage: strobe for one cycle after each pop; select/data hold between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable <= 1'b0;
      write_select <= '0;
      reg_input    <= '0;
    end else begin
      write_enable <= pop;
      if (pop) begin
        write_select <= head_entry[ENTRY_W-1:DATA_W];
        reg_input    <= head_entry[DATA_W-1:0];
      end
    end
  end

  // Per-register increment on accept, decrement as a strobe retires, and the pending flags.
  always_comb begin
    sb_inc  = '0;
    sb_dec  = '0;
    pending = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      sb_inc[r]  = push & (push_entry[ENTRY_W-1:DATA_W] == SEL_W'(r));
      sb_dec[r]  = write_enable & (write_select == SEL_W'(r));
      pending[r] = (sb_count[r] != '0);
    end
  end

  // Scoreboard counters; simultaneous increment and decrement cancel out.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reset) begin
        sb_count[r] <= '0;
      end else if (sb_inc[r] & ~sb_dec[r]) begin
        sb_count[r] <= sb_count[r] + 1'b1;
      end else if (~sb_inc[r] & sb_dec[r]) begin
        sb_count[r] <= sb_count[r] - 1'b1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  logic [SEL_W-1:0]   query    [2];
  logic               hit      [2];
  logic [DATA_W-1:0]  hit_data [2];
  logic [PTR_W-1:0]   slot_idx;
  logic [ENTRY_W-1:0] slot_entry;

  assign query[0]     = query_select0;
  assign query[1]     = query_select1;
  assign bypass_hit0  = hit[0];
  assign bypass_hit1  = hit[1];
  assign bypass_data0 = hit_data[0];
  assign bypass_data1 = hit_data[1];

  // Youngest match wins: the write stage is oldest, then walk the queue from head to tail.
  always_comb begin
    slot_idx   = '0;
    slot_entry = '0;
    for (int q = 0; q < 2; q++) begin
      hit[q]      = 1'b0;
      hit_data[q] = '0;
      if (write_enable && (write_select == query[q])) begin
        hit[q]      = 1'b1;
        hit_data[q] = reg_input;
      end
      for (int i = 0; i < DEPTH; i++) begin
        slot_idx   = fifo_rd_ptr + PTR_W'(i);
        slot_entry = fifo_slots[int'(slot_idx)*ENTRY_W +: ENTRY_W];
        if ((CNT_W'(i) < fifo_count) && (slot_entry[ENTRY_W-1:DATA_W] == query[q])) begin
          hit[q]      = 1'b1;
          hit_data[q] = slot_entry[DATA_W-1:0];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: directed vector table, hand sequences for
// stall/full, reset-discard and bypass (when WB_BYPASS_EN is defined), then random traffic
// against a queue-based reference model.
module tb_reg_writeback_queue;
  import i281_wb_pkg::*;

  localparam int DEPTH = WB_DEPTH;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_wb_valid, load_wb_valid, drain_stall;
  logic [1:0] alu_wb_select, load_wb_select;
  logic [7:0] alu_wb_data, load_wb_data;
  logic       alu_wb_ready, load_wb_ready;
  logic       write_enable;
  logic [1:0] write_select;
  logic [7:0] reg_input;
  logic [3:0] pending;
  logic       empty;
`ifdef WB_BYPASS_EN
  logic [1:0] query_select0, query_select1;
  logic       bypass_hit0, bypass_hit1;
  logic [7:0] bypass_data0, bypass_data1;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: queued entries plus the write stage.
  wb_entry_t  mq[$];
  logic       m_sv;
  logic [1:0] m_ss;
  logic [7:0] m_sd;

  logic [7:0] rf [4];

  typedef struct {
    logic lv; logic [1:0] ls; logic [7:0] ld;
    logic av; logic [1:0] asel; logic [7:0] ad;
    logic stall;
    logic e_lr; logic e_ar; logic e_we; logic [1:0] e_sel; logic [7:0] e_data;
    logic [3:0] e_pend; logic e_empty;
  } vec_t;

  vec_t vecs [11];

  reg_writeback_queue dut (
    .clk            (clk),
    .reset          (reset),
    .alu_wb_valid   (alu_wb_valid),
    .alu_wb_select  (alu_wb_select),
    .alu_wb_data    (alu_wb_data),
    .alu_wb_ready   (alu_wb_ready),
    .load_wb_valid  (load_wb_valid),
    .load_wb_select (load_wb_select),
    .load_wb_data   (load_wb_data),
    .load_wb_ready  (load_wb_ready),
    .drain_stall    (drain_stall),
    .write_enable   (write_enable),
    .write_select   (write_select),
    .reg_input      (reg_input),
    .pending        (pending),
    .empty          (empty)
`ifdef WB_BYPASS_EN
    ,
    .query_select0  (query_select0),
    .query_select1  (query_select1),
    .bypass_hit0    (bypass_hit0),
    .bypass_hit1    (bypass_hit1),
    .bypass_data0   (bypass_data0),
    .bypass_data1   (bypass_data1)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Register file model fed by the DUT's write port, to observe what actually lands.
  always @(posedge clk) begin
    if (write_enable === 1'b1) rf[write_select] <= reg_input;
  end

  function automatic vec_t mkv(input logic lv, input logic [1:0] ls, input logic [7:0] ld,
                               input logic av, input logic [1:0] asel, input logic [7:0] ad,
                               input logic stall, input logic lr, input logic ar,
                               input logic we, input logic [1:0] sel, input logic [7:0] data,
                               input logic [3:0] pend, input logic emp);
    vec_t v;
    v.lv = lv; v.ls = ls; v.ld = ld; v.av = av; v.asel = asel; v.ad = ad; v.stall = stall;
    v.e_lr = lr; v.e_ar = ar; v.e_we = we; v.e_sel = sel; v.e_data = data;
    v.e_pend = pend; v.e_empty = emp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] modelPending();
    logic [3:0] p = '0;
    foreach (mq[i]) p[mq[i].sel] = 1'b1;
    if (m_sv) p[m_ss] = 1'b1;
    return p;
  endfunction

  // Drive one cycle of inputs, sample readies before the edge, then advance the model at the edge.
  task automatic applyStimulus(input logic rst, input logic lv, input logic [1:0] ls,
                               input logic [7:0] ld, input logic av, input logic [1:0] asel,
                               input logic [7:0] ad, input logic stall, input bit chkReady,
                               output logic lr_s, output logic ar_s);
    bit full;
    bit popNow;
    reset = rst; load_wb_valid = lv; load_wb_select = ls; load_wb_data = ld;
    alu_wb_valid = av; alu_wb_select = asel; alu_wb_data = ad; drain_stall = stall;
    #2;
    lr_s = load_wb_ready;
    ar_s = alu_wb_ready;
    full = (mq.size() >= DEPTH);
    if (chkReady) begin
      check("load_ready", {31'd0, lr_s}, {31'd0, !full});
      check("alu_ready", {31'd0, ar_s}, {31'd0, !full && !lv});
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_sv = 1'b0; m_ss = '0; m_sd = '0;
    end else begin
      popNow = (mq.size() != 0) && !stall;
      if (popNow) begin
        wb_entry_t e = mq.pop_front();
        m_sv = 1'b1; m_ss = e.sel; m_sd = e.data;
      end else begin
        m_sv = 1'b0;
      end
      if ((lv || av) && !full) mq.push_back(lv ? make_entry(ls, ld) : make_entry(asel, ad));
    end
    #1;
  endtask

  // Compare registered outputs (and bypass results when present) with the model.
  task automatic checkOutput();
    check("write_enable", {31'd0, write_enable}, {31'd0, m_sv});
    check("write_select", {30'd0, write_select}, {30'd0, m_ss});
    check("reg_input", {24'd0, reg_input}, {24'd0, m_sd});
    check("pending", {28'd0, pending}, {28'd0, modelPending()});
    check("empty", {31'd0, empty}, {31'd0, (mq.size() == 0) && !m_sv});
`ifdef WB_BYPASS_EN
    begin
      logic [1:0] qs [2];
      logic       eh [2];
      logic [7:0] ed [2];
      qs[0] = 2'($urandom_range(0, 3));
      qs[1] = 2'($urandom_range(0, 3));
      query_select0 = qs[0];
      query_select1 = qs[1];
      for (int q = 0; q < 2; q++) begin
        eh[q] = 1'b0; ed[q] = '0;
        if (m_sv && m_ss == qs[q]) begin eh[q] = 1'b1; ed[q] = m_sd; end
        foreach (mq[i]) if (mq[i].sel == qs[q]) begin eh[q] = 1'b1; ed[q] = mq[i].data; end
      end
      #1;
      check("bypass_hit0", {31'd0, bypass_hit0}, {31'd0, eh[0]});
      check("bypass_hit1", {31'd0, bypass_hit1}, {31'd0, eh[1]});
      if (eh[0]) check("bypass_data0", {24'd0, bypass_data0}, {24'd0, ed[0]});
      if (eh[1]) check("bypass_data1", {24'd0, bypass_data1}, {24'd0, ed[1]});
    end
`endif
  endtask

  initial begin
    logic lr_s, ar_s;
    m_sv = 1'b0; m_ss = '0; m_sd = '0;
    reset = 1'b1; alu_wb_valid = 0; load_wb_valid = 0; drain_stall = 0;
    alu_wb_select = 0; load_wb_select = 0; alu_wb_data = 0; load_wb_data = 0;
`ifdef WB_BYPASS_EN
    query_select0 = 0; query_select1 = 0;
`endif

    // Directed table: single write, load-over-ALU priority, two writes to the same register.
    vecs[0]  = mkv(0,0,8'h00, 1,2,8'h5A, 0,  1,1, 0,0,8'h00, 4'b0100, 0);
    vecs[1]  = mkv(0,0,8'h00, 0,0,8'h00, 0,  1,1, 1,2,8'h5A, 4'b0100, 0);
    vecs[2]  = mkv(0,0,8'h00, 0,0,8'h00, 0,  1,1, 0,2,8'h5A, 4'b0000, 1);
    vecs[3]  = mkv(1,1,8'h11, 1,3,8'h33, 0,  1,0, 0,2,8'h5A, 4'b0010, 0);
    vecs[4]  = mkv(0,0,8'h00, 1,3,8'h33, 0,  1,1, 1,1,8'h11, 4'b1010, 0);
    vecs[5]  = mkv(0,0,8'h00, 0,0,8'h00, 0,  1,1, 1,3,8'h33, 4'b1000, 0);
    vecs[6]  = mkv(0,0,8'h00, 0,0,8'h00, 0,  1,1, 0,3,8'h33, 4'b0000, 1);
    vecs[7]  = mkv(0,0,8'h00, 1,0,8'h01, 0,  1,1, 0,3,8'h33, 4'b0001, 0);
    vecs[8]  = mkv(0,0,8'h00, 1,0,8'h02, 0,  1,1, 1,0,8'h01, 4'b0001, 0);
    vecs[9]  = mkv(0,0,8'h00, 0,0,8'h00, 0,  1,1, 1,0,8'h02, 4'b0001, 0);
    vecs[10] = mkv(0,0,8'h00, 0,0,8'h00, 0,  1,1, 0,0,8'h02, 4'b0000, 1);

    // Reset state.
    applyStimulus(1, 0,0,0, 0,0,0, 0, 0, lr_s, ar_s);
    applyStimulus(1, 0,0,0, 0,0,0, 0, 1, lr_s, ar_s);
    check("rst_we", {31'd0, write_enable}, 32'd0);
    check("rst_sel", {30'd0, write_select}, 32'd0);
    check("rst_data", {24'd0, reg_input}, 32'd0);
    check("rst_pending", {28'd0, pending}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(0, vecs[i].lv, vecs[i].ls, vecs[i].ld, vecs[i].av, vecs[i].asel,
                    vecs[i].ad, vecs[i].stall, 1, lr_s, ar_s);
      check("tbl_lready", {31'd0, lr_s}, {31'd0, vecs[i].e_lr});
      check("tbl_aready", {31'd0, ar_s}, {31'd0, vecs[i].e_ar});
      check("tbl_we", {31'd0, write_enable}, {31'd0, vecs[i].e_we});
      check("tbl_sel", {30'd0, write_select}, {30'd0, vecs[i].e_sel});
      check("tbl_data", {24'd0, reg_input}, {24'd0, vecs[i].e_data});
      check("tbl_pending", {28'd0, pending}, {28'd0, vecs[i].e_pend});
      check("tbl_empty", {31'd0, empty}, {31'd0, vecs[i].e_empty});
      checkOutput();
    end
    check("regA_last_wins", {24'd0, rf[0]}, 32'h02);

    // Stall fills the queue, fifth request refused, release drains in order.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, (i % 2 == 0), 2'(i), 8'hC0 + 8'(i), (i % 2 == 1), 2'(i), 8'hC0 + 8'(i),
                    1, 1, lr_s, ar_s);
      checkOutput();
    end
    applyStimulus(0, 1,0,8'hEE, 1,1,8'hEF, 1, 1, lr_s, ar_s);
    check("full_lready", {31'd0, lr_s}, 32'd0);
    check("full_aready", {31'd0, ar_s}, 32'd0);
    checkOutput();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0,0,0, 0,0,0, 0, 1, lr_s, ar_s);
      check("drain_we", {31'd0, write_enable}, 32'd1);
      check("drain_sel", {30'd0, write_select}, i);
      check("drain_data", {24'd0, reg_input}, 32'hC0 + i);
      checkOutput();
    end
    applyStimulus(0, 0,0,0, 0,0,0, 0, 1, lr_s, ar_s);
    checkOutput();

    // Reset with three entries queued discards them.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0,0,0, 1, 2'(i+1), 8'h70 + 8'(i), 1, 1, lr_s, ar_s);
      checkOutput();
    end
    applyStimulus(1, 0,0,0, 0,0,0, 0, 1, lr_s, ar_s);
    check("rstq_we", {31'd0, write_enable}, 32'd0);
    check("rstq_pending", {28'd0, pending}, 32'd0);
    check("rstq_empty", {31'd0, empty}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0,0,0, 0,0,0, 0, 1, lr_s, ar_s);
      check("rstq_no_strobe", {31'd0, write_enable}, 32'd0);
      checkOutput();
    end

`ifdef WB_BYPASS_EN
    // Bypass returns the youngest of two queued writes to the same register.
    applyStimulus(0, 0,0,0, 1,3,8'hAA, 1, 1, lr_s, ar_s);
    applyStimulus(0, 0,0,0, 1,3,8'hBB, 1, 1, lr_s, ar_s);
    query_select0 = 2'd3;
    #1;
    check("byp_hit3", {31'd0, bypass_hit0}, 32'd1);
    check("byp_data3", {24'd0, bypass_data0}, 32'hBB);
    query_select0 = 2'd1;
    #1;
    check("byp_hit1", {31'd0, bypass_hit0}, 32'd0);
    applyStimulus(1, 0,0,0, 0,0,0, 0, 1, lr_s, ar_s);
    checkOutput();
`endif

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 8'($urandom),
                    ($urandom_range(0, 1) == 0), 2'($urandom_range(0, 3)), 8'($urandom),
                    ($urandom_range(0, 2) == 0), 1, lr_s, ar_s);
      checkOutput();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
